lpm_mem_arb: RTL

LPM_MEM_ARB -- requirements
Module: lpm_mem_arb

---
 rtl/lpm_mem_arb.sv | 102 ++++++++++
 1 files changed

// File: rtl/lpm_mem_arb.sv
// Two-requester memory arbiter: A has priority, and B is forced through after STARVE_LIMIT
// consecutive A grants taken while B was waiting. Responses return in order, routed by a tag FIFO.
module lpm_mem_arb #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     reqA__ENA,
  input  logic [WIDTH-1:0]         reqA_v,
  output logic                     reqA__RDY,
  input  logic                     reqB__ENA,
  input  logic [WIDTH-1:0]         reqB_v,
  output logic                     reqB__RDY,
  output logic                     resA_enq__ENA,
  output logic [WIDTH-1:0]         resA_enq_v,
  input  logic                     resA_enq__RDY,
  output logic                     resB_enq__ENA,
  output logic [WIDTH-1:0]         resB_enq_v,
  input  logic                     resB_enq__RDY,
  output logic                     mem_req__ENA,
  output logic [WIDTH-1:0]         mem_req_v,
  input  logic                     mem_req__RDY,
  input  logic [WIDTH-1:0]         mem_resValue,
  input  logic                     mem_resValue__RDY,
  output logic                     mem_resAccept__ENA,
  input  logic                     mem_resAccept__RDY,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] count;
  logic [SW-1:0] starve;
  logic          err_q;
  logic          tag_mem [DEPTH];

  logic base, starved, grant_a, grant_b, push, pop, head_tag, head_ready, spurious;

  always_comb begin
    base     = mem_req__RDY && (count < OW'(DEPTH)) && nRST;
    starved  = (starve == SW'(STARVE_LIMIT));
    reqA__RDY = base && !(reqB__ENA && starved);
    reqB__RDY = base && !(reqA__ENA && !starved);
    grant_a  = reqA__ENA && reqA__RDY;
    grant_b  = reqB__ENA && reqB__RDY;
    push     = grant_a || grant_b;

    mem_req__ENA = push;
    mem_req_v    = '0;
    if (grant_a)      mem_req_v = reqA_v;
    else if (grant_b) mem_req_v = reqB_v;
  end

  // Head tag selects the destination; a blocked destination stalls every later response.
  always_comb begin
    head_tag   = tag_mem[rd_ptr];
    head_ready = head_tag ? resB_enq__RDY : resA_enq__RDY;
    pop        = nRST && mem_resValue__RDY && (count != '0) && mem_resAccept__RDY && head_ready;
    spurious   = mem_resValue__RDY && (count == '0);

    mem_resAccept__ENA = pop;
    resA_enq__ENA = pop && !head_tag;
    resB_enq__ENA = pop && head_tag;
    resA_enq_v    = '0;
    resB_enq_v    = '0;
    if (pop && !head_tag) resA_enq_v = mem_resValue;
    if (pop && head_tag)  resB_enq_v = mem_resValue;

    outstanding = nRST ? count : '0;
    err         = nRST && err_q;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + OW'(push) - OW'(pop);
      if (grant_b)
        starve <= '0;
      else if (grant_a && reqB__ENA && !starved)
        starve <= starve + SW'(1);
      if (spurious) err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) tag_mem[wr_ptr] <= grant_b;
  end

endmodule
